openhmc_sync_fifo_rd_port: RTL and testbench

Read-side port for the openHMC shift-register synchronous FIFO. It monitors the FIFO head stage, issues the shift-out strobe, and presents the words on a valid/ready stream to the downstream consumer through a 2-entry skid buffer. The skid buffer keeps `fifo_so` free of any combinational path from `dout_ready`. It also supports a drain/flush mode that empties both the skid buffer and the FIFO.

---
 rtl/openhmc_sync_fifo_rd_port_if.sv | 21 ++
 rtl/openhmc_sync_fifo_rd_port.sv | 108 ++++++++++
 tb/tb_openhmc_sync_fifo_rd_port.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/openhmc_sync_fifo_rd_port_if.sv
// Output stream of the openHMC sync FIFO read port: data/valid toward the
// consumer, ready back from it.
interface openhmc_sync_fifo_rd_port_if #(
    parameter int unsigned DWIDTH = 8
);
    logic [DWIDTH-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/openhmc_sync_fifo_rd_port.sv
// Read port of the openHMC shift-register FIFO: 2-entry skid buffer plus drain/flush.
// Optional delivered-word counter enabled by OPENHMC_SYNC_FIFO_RD_PORT_CNT_EN.
module openhmc_sync_fifo_rd_port #(
    parameter int unsigned DWIDTH   = 8,
    parameter int unsigned CNTWIDTH = 16
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic                          fifo_head_full,
    input  logic [DWIDTH-1:0]             fifo_d,
    output logic                          fifo_so,
    openhmc_sync_fifo_rd_port_if.master   dout_if,
    input  logic                          flush,
    output logic                          empty,
    output logic [CNTWIDTH-1:0]           pop_cnt
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] e0_q, e0_d;
    logic [DWIDTH-1:0] e1_q, e1_d;
    logic              dout_valid;
    logic              push;
    logic              pop;

    // fifo_so uses registered state only, never dout_ready
    always_comb begin
        fifo_so    = fifo_head_full & (flush | (state_q != S2));
        dout_valid = (state_q != S0) & ~flush;
        push       = fifo_so & ~flush;
        pop        = dout_valid & dout_if.dout_ready;
        state_d    = state_q;
        e0_d       = e0_q;
        e1_d       = e1_q;
        if (flush) begin
            state_d = S0;
        end else begin
            unique case (state_q)
                S0: begin
                    if (push) begin
                        e0_d    = fifo_d;
                        state_d = S1;
                    end
                end
                S1: begin
                    unique case ({push, pop})
                        2'b10: begin
                            e1_d    = fifo_d;
                            state_d = S2;
                        end
                        2'b01: state_d = S0;
                        2'b11: e0_d    = fifo_d;
                        default: ;
                    endcase
                end
                S2: begin
                    if (pop) begin
                        e0_d    = e1_q;
                        state_d = S1;
                    end
                end
                default: state_d = S0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= S0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            state_q <= state_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

    assign dout_if.dout       = e0_q;
    assign dout_if.dout_valid = dout_valid;
    assign empty              = (state_q == S0) & ~fifo_head_full;

`ifdef OPENHMC_SYNC_FIFO_RD_PORT_CNT_EN
    logic [CNTWIDTH-1:0] pop_cnt_q, pop_cnt_d;

    always_comb begin
        pop_cnt_d = pop_cnt_q + CNTWIDTH'(pop);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            pop_cnt_q <= '0;
        end else begin
            pop_cnt_q <= pop_cnt_d;
        end
    end

    assign pop_cnt = pop_cnt_q;
`else
    assign pop_cnt = '0;
`endif

endmodule

// File: tb/tb_openhmc_sync_fifo_rd_port.sv
// Directed bench for openhmc_sync_fifo_rd_port with a behavioural FIFO source
// and an in-order scoreboard; a second instance (CNTWIDTH=4) covers counter wrap.
module tb_openhmc_sync_fifo_rd_port;

`ifdef OPENHMC_SYNC_FIFO_RD_PORT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        res;
    logic        fifo_head_full;
    logic [7:0]  fifo_d;
    logic        fifo_so;
    logic        fifo_so4;
    logic        flush;
    logic        empty;
    logic        empty4;
    logic        dout_ready;
    logic [15:0] pop_cnt;
    logic [3:0]  pop_cnt4;

    openhmc_sync_fifo_rd_port_if #(.DWIDTH(8)) rd_if ();
    openhmc_sync_fifo_rd_port_if #(.DWIDTH(8)) rd_if4 ();

    assign rd_if.dout_ready  = dout_ready;
    assign rd_if4.dout_ready = dout_ready;

    openhmc_sync_fifo_rd_port #(.DWIDTH(8), .CNTWIDTH(16)) dut (
        .clk            (clk),
        .res            (res),
        .fifo_head_full (fifo_head_full),
        .fifo_d         (fifo_d),
        .fifo_so        (fifo_so),
        .dout_if        (rd_if),
        .flush          (flush),
        .empty          (empty),
        .pop_cnt        (pop_cnt)
    );

    openhmc_sync_fifo_rd_port #(.DWIDTH(8), .CNTWIDTH(4)) dut4 (
        .clk            (clk),
        .res            (res),
        .fifo_head_full (fifo_head_full),
        .fifo_d         (fifo_d),
        .fifo_so        (fifo_so4),
        .dout_if        (rd_if4),
        .flush          (flush),
        .empty          (empty4),
        .pop_cnt        (pop_cnt4)
    );

    always #5 clk = ~clk;

    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    bit         head_en;
    int         pops;
    int         so_cnt;
    int         n_assert;
    int         n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic apply_inputs();
        fifo_head_full = head_en && (src_q.size() != 0);
        fifo_d         = (src_q.size() != 0) ? src_q[0] : 8'h00;
    endtask

    // One clock: drive source, observe at negedge, update models, return at posedge+1
    task automatic step();
        logic       so;
        logic       v;
        logic [7:0] d;
        logic [7:0] w;
        apply_inputs();
        @(negedge clk);
        so = fifo_so;
        v  = rd_if.dout_valid;
        d  = rd_if.dout;
        if (flush) chk("flush_valid", v, 0);
        if (so) chk("so_needs_head", fifo_head_full, 1);
        if (v && dout_ready) begin
            chk("pop_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("order", d, w);
            end
            pops++;
        end
        if (so) begin
            if (src_q.size() != 0) begin
                w = src_q.pop_front();
                if (!flush) exp_q.push_back(w);
            end
            so_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && guard < 400) begin
            step();
            guard++;
        end
        chk(tag, src_q.size() + exp_q.size(), 0);
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        return CNT_EN ? 32'(n & 16'hFFFF) : 32'd0;
    endfunction

    initial begin
        int steps;
        int so_before;
        int cnt_before;
        n_assert       = 0;
        n_fail         = 0;
        pops           = 0;
        so_cnt         = 0;
        head_en        = 1'b0;
        flush          = 1'b0;
        dout_ready     = 1'b0;
        fifo_d         = 8'h00;
        res            = 1'b1;
        fifo_head_full = 1'b1;
        #2;
        // Reset state; fifo_so follows head_full combinationally
        chk("rst_so", fifo_so, 1);
        chk("rst_valid", rd_if.dout_valid, 0);
        chk("rst_dout", rd_if.dout, 0);
        chk("rst_cnt", pop_cnt, 0);
        chk("rst_empty_headfull", empty, 0);
        fifo_head_full = 1'b0;
        #1;
        chk("rst_empty", empty, 1);
        @(posedge clk);
        #1;
        res = 1'b0;

        // Streaming 0x01..0x10
        for (int unsigned i = 1; i <= 16; i++) src_q.push_back(8'(i));
        head_en    = 1'b1;
        dout_ready = 1'b1;
        apply_inputs();
        #1;
        chk("stream_first_valid_pre", rd_if.dout_valid, 0);
        step();
        chk("stream_lat_valid", rd_if.dout_valid, 1);
        chk("stream_lat_dout", rd_if.dout, 8'h01);
        steps = 1;
        while ((src_q.size() != 0 || exp_q.size() != 0) && steps < 100) begin
            step();
            steps++;
        end
        chk("stream_cycles", steps, 17);
        chk("stream_cnt", pop_cnt, exp_cnt(pops));
        chk("stream_pops", pops, 16);

        // Backpressure
        dout_ready = 1'b0;
        for (int unsigned i = 0; i < 4; i++) src_q.push_back(8'(8'h21 + i));
        so_before = so_cnt;
        for (int unsigned i = 0; i < 5; i++) step();
        chk("bp_so_pulses", so_cnt - so_before, 2);
        chk("bp_valid", rd_if.dout_valid, 1);
        chk("bp_hold", rd_if.dout, 8'h21);
        dout_ready = 1'b1;
        so_before  = so_cnt;
        step();
        chk("bp_so_still_low", so_cnt - so_before, 0);
        step();
        chk("bp_so_resumes", so_cnt - so_before, 1);
        drain("bp_drain");
        chk("bp_cnt", pop_cnt, exp_cnt(pops));

        // Random push/pop patterns
        for (int unsigned i = 0; i < 100; i++) src_q.push_back(8'($urandom_range(0, 255)));
        for (int unsigned i = 0; i < 100; i++) begin
            head_en    = 1'($urandom_range(0, 1));
            dout_ready = 1'($urandom_range(0, 1));
            step();
        end
        head_en    = 1'b1;
        dout_ready = 1'b1;
        drain("rand_drain");
        chk("rand_cnt", pop_cnt, exp_cnt(pops));

        // Flush from S2 holding 0xAA,0xBB with three words still in the FIFO
        dout_ready = 1'b0;
        src_q.push_back(8'hAA);
        src_q.push_back(8'hBB);
        src_q.push_back(8'h01);
        src_q.push_back(8'h02);
        src_q.push_back(8'h03);
        step();
        step();
        chk("fl_pre_dout", rd_if.dout, 8'hAA);
        chk("fl_pre_valid", rd_if.dout_valid, 1);
        cnt_before = pops;
        exp_q.delete();
        flush      = 1'b1;
        dout_ready = 1'b1;
        so_before  = so_cnt;
        for (int unsigned i = 0; i < 4; i++) step();
        chk("fl_so_pulses", so_cnt - so_before, 3);
        apply_inputs();
        #1;
        chk("fl_empty", empty, 1);
        chk("fl_cnt_unchanged", pop_cnt, exp_cnt(cnt_before));
        flush = 1'b0;
        src_q.push_back(8'hCC);
        step();
        chk("fl_after_valid", rd_if.dout_valid, 1);
        chk("fl_after_dout", rd_if.dout, 8'hCC);
        step();
        chk("fl_after_pops", pops - cnt_before, 1);

        // Asynchronous reset while in S2
        dout_ready = 1'b0;
        src_q.push_back(8'h31);
        src_q.push_back(8'h32);
        step();
        step();
        chk("rr_pre_valid", rd_if.dout_valid, 1);
        #2;
        res = 1'b1;
        #1;
        chk("rr_valid", rd_if.dout_valid, 0);
        chk("rr_dout", rd_if.dout, 0);
        chk("rr_cnt", pop_cnt, 0);
        chk("rr_cnt4", pop_cnt4, 0);
        src_q.delete();
        exp_q.delete();
        pops = 0;
        @(posedge clk);
        #1;
        res = 1'b0;
        apply_inputs();
        #1;
        chk("rr_empty", empty, 1);
        chk("rr_valid_after", rd_if.dout_valid, 0);

        // Counter wrap on the CNTWIDTH=4 instance: 17 pops
        dout_ready = 1'b1;
        for (int unsigned i = 0; i < 17; i++) src_q.push_back(8'(8'h40 + i));
        drain("wrap_drain");
        chk("wrap_pops", pops, 17);
        chk("wrap_cnt4", pop_cnt4, CNT_EN ? 32'(pops % 16) : 32'd0);
        chk("wrap_cnt16", pop_cnt, exp_cnt(pops));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
